// File: rtl/imem_line_server_pkg.sv
// Shared types and calibration constants for the instruction-memory responder
// and the I-cache controller that calibrates against it.
package imem_line_server_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        WAIT  = 2'd2,
        BURST = 2'd3
    } imem_state_t;

    localparam int unsigned IMEM_CAL_ADDR    = 1;
    localparam logic [31:0] IMEM_CAL_PATTERN = 32'hFFFF_FFFF;

    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/imem_line_server_array.sv
// Single-port instruction storage, synchronous read with one cycle of latency.
// Contents are never reset; only the read register is.
module imem_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // The read register only loads on a beat, so it holds the last beat between bursts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/imem_line_server.sv
// Instruction-fetch miss responder: fixed-latency line bursts and single-word writes.
// Optional build macro IMEM_PARITY_EN adds per-word even parity (inj_perr, rsp_perr).
//
// state | meaning
// IDLE  | waiting for an armed mem_cs
// WRITE | single-word write into the array, wr_done pulses
// WAIT  | counting out the fixed read latency
// BURST | one beat per cycle from the aligned line
module imem_line_server
    import imem_line_server_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 13,
    localparam int IDX_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              mem_cs,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              mem_abort,
`ifdef IMEM_PARITY_EN
    input  logic              inj_perr,
    output logic              rsp_perr,
`endif
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic [IDX_W-1:0]  rsp_idx,
    output logic              rsp_last,
    output logic              wr_done,
    output logic              busy
);

    localparam int CNT_W = 4;
`ifdef IMEM_PARITY_EN
    localparam int DATA_W = 33;
`else
    localparam int DATA_W = 32;
`endif
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LATENCY - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(LINE_WORDS - 1);

    imem_state_t state_q, state_d;

    logic              armed_q;
    logic              accept;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              wr_done_q, wr_done_d;

    logic              arr_re;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;

    assign accept  = (state_q == IDLE) && mem_cs && armed_q;
    assign idx_nxt = idx_q + IDX_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        valid_d   = 1'b0;
        last_d    = last_q;
        wr_done_d = 1'b0;
        arr_re    = 1'b0;
        arr_we    = 1'b0;
        arr_addr  = addr_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!mem_wen) begin
                        state_d   = WRITE;
                        wr_done_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            WRITE: begin
                arr_we  = 1'b1;
                state_d = IDLE;
            end
            WAIT: begin
                if (mem_abort) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // The final wait cycle issues beat 0 so the array's read cycle lands on time.
                    arr_re  = 1'b1;
                    state_d = BURST;
                    valid_d = 1'b1;
                    idx_d   = '0;
                    last_d  = (LINE_WORDS == 1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BURST: begin
                if (mem_abort || last_q) begin
                    state_d = IDLE;
                end else begin
                    arr_re   = 1'b1;
                    arr_addr = addr_q | ADDR_W'(idx_nxt);
                    valid_d  = 1'b1;
                    idx_d    = idx_nxt;
                    last_d   = (idx_nxt == IDX_LAST);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            armed_q   <= 1'b1;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= !mem_cs || (armed_q && !accept);
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            wr_done_q <= wr_done_d;
            if (accept) begin
                // Reads keep only the line base; writes keep the exact word address.
                addr_q  <= mem_wen ? (mem_addr & ~LINE_MASK) : mem_addr;
                wdata_q <= mem_wdata;
            end
        end
    end

`ifdef IMEM_PARITY_EN
    logic wpar_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wpar_q <= 1'b0;
        end else if (accept) begin
            wpar_q <= even_parity(mem_wdata) ^ inj_perr;
        end
    end

    assign arr_wdata = {wpar_q, wdata_q};
    assign rsp_data  = arr_rdata[31:0];
    assign rsp_perr  = valid_q && (even_parity(arr_rdata[31:0]) != arr_rdata[32]);
`else
    assign arr_wdata = wdata_q;
    assign rsp_data  = arr_rdata;
`endif

    imem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .rstn  (rstn),
        .re    (arr_re),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    assign rsp_valid = valid_q;
    assign rsp_idx   = idx_q;
    assign rsp_last  = last_q;
    assign wr_done   = wr_done_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_imem_line_server.sv
// Scoreboard bench for imem_line_server: directed accesses push expected beats and
// write completions; a negedge monitor pops and compares data, index, last and cycle.
module tb_imem_line_server;
    import imem_line_server_pkg::*;

    localparam int LAT = 13;

    logic        clk, rstn, mem_cs, mem_wen, mem_abort;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        rsp_valid, rsp_last, wr_done, busy;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_idx;
    logic        perr_act;
    logic        inj_req = 1'b0;
`ifdef IMEM_PARITY_EN
    logic        inj_perr, rsp_perr;
    assign inj_perr = inj_req;
    assign perr_act = rsp_perr;
`else
    assign perr_act = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic [1:0]  idx;
        logic        last;
        logic        perr;
        int          cyc;
    } beat_t;

    beat_t       bq[$];
    int          wq[$];
    beat_t       e;
    int          we_cyc;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          acc;
    int          busy_cnt;
    logic [31:0] model  [1024];
    logic        pmodel [1024];

    imem_line_server dut (
        .clk       (clk),
        .rstn      (rstn),
        .mem_cs    (mem_cs),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_abort (mem_abort),
`ifdef IMEM_PARITY_EN
        .inj_perr  (inj_perr),
        .rsp_perr  (rsp_perr),
`endif
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_idx   (rsp_idx),
        .rsp_last  (rsp_last),
        .wr_done   (wr_done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn && rsp_valid) begin
            n_tests++;
            if (bq.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_beat: got data=%h idx=%0d at cyc %0d, expected no beat",
                         rsp_data, rsp_idx, cyc);
            end else begin
                e = bq.pop_front();
                if (rsp_data !== e.data || rsp_idx !== e.idx || rsp_last !== e.last ||
                    perr_act !== e.perr || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL beat: got data=%h idx=%0d last=%0d perr=%0d cyc=%0d, expected data=%h idx=%0d last=%0d perr=%0d cyc=%0d",
                             rsp_data, rsp_idx, rsp_last, perr_act, cyc,
                             e.data, e.idx, e.last, e.perr, e.cyc);
                end
            end
        end
        if (rstn && wr_done) begin
            n_tests++;
            if (wq.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_wr_done: got pulse at cyc %0d, expected none", cyc);
            end else begin
                we_cyc = wq.pop_front();
                if (cyc != we_cyc) begin
                    n_fail++;
                    $display("FAIL wr_done_cycle: got cyc %0d, expected cyc %0d", cyc, we_cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_cs    = 1'b1;
        mem_wen   = 1'b0;
        mem_addr  = a;
        mem_wdata = d;
        wq.push_back(cyc + 1);
        model[a]  = d;
        pmodel[a] = inj_req;
        @(negedge clk);
        mem_cs  = 1'b0;
        mem_wen = 1'b1;
    endtask

    // Pushes the first nb beats of the line containing a; beat k is due LAT+k edges after accept.
    task automatic do_read(input logic [9:0] a, input int nb, output int acc_cyc);
        logic [9:0] b;
        beat_t      x;
        @(negedge clk);
        mem_cs   = 1'b1;
        mem_wen  = 1'b1;
        mem_addr = a;
        acc_cyc  = cyc + 1;
        for (int k = 0; k < nb; k++) begin
            b      = (a & 10'h3FC) + 10'(k);
            x.data = model[b];
            x.idx  = 2'(k);
            x.last = (k == 3);
            x.perr = pmodel[b];
            x.cyc  = acc_cyc + LAT + k;
            bq.push_back(x);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn      = 1'b0;
        mem_cs    = 1'b0;
        mem_wen   = 1'b1;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_data",  rsp_data, 32'd0);
        chk("rst_idx",   {30'd0, rsp_idx}, 32'd0);
        chk("rst_last",  {31'd0, rsp_last}, 32'd0);
        chk("rst_wr_done", {31'd0, wr_done}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        rstn = 1'b1;

        // Calibration: write the pattern, read it back with exact latency.
        do_write(10'd0, 32'h1111_0000);
        do_write(10'd2, 32'h2222_0002);
        do_write(10'd3, 32'h3333_0003);
        do_write(10'(IMEM_CAL_ADDR), IMEM_CAL_PATTERN);
        do_read(10'(IMEM_CAL_ADDR), 4, acc);
        @(negedge clk);
        chk("busy_rise", {31'd0, busy}, 32'd1);
        wait_idle("cal_idle");
        mem_cs = 1'b0;

        // Line burst from a mid-line address.
        for (int i = 0; i < 4; i++) do_write(10'(8 + i), 32'hA0 + 32'(i));
        do_read(10'd10, 4, acc);
        wait_idle("burst_idle");

        // Held mem_cs must not re-trigger.
        mem_cs = 1'b0;
        do_read(10'd8, 4, acc);
        wait_idle("held_idle");
        busy_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        chk("held_no_reaccept", 32'(busy_cnt), 32'd0);
        mem_cs = 1'b0;

        // Abort during WAIT, then a normal read.
        do_read(10'd8, 0, acc);
        while (cyc < acc + 5) @(negedge clk);
        mem_abort = 1'b1;
        @(negedge clk);
        chk("abort_wait_busy",  {31'd0, busy}, 32'd0);
        chk("abort_wait_valid", {31'd0, rsp_valid}, 32'd0);
        mem_abort = 1'b0;
        mem_cs    = 1'b0;
        repeat (LAT + 6) @(negedge clk);
        do_read(10'd8, 4, acc);
        wait_idle("post_abort_idle");
        mem_cs = 1'b0;

        // Abort at beat 2: outputs hold, no beat 3.
        do_read(10'd8, 3, acc);
        while (cyc < acc + LAT + 2) @(negedge clk);
        mem_abort = 1'b1;
        @(negedge clk);
        chk("abort_burst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_burst_hold",  rsp_data, model[10]);
        chk("abort_burst_idx",   {30'd0, rsp_idx}, 32'd2);
        chk("abort_burst_busy",  {31'd0, busy}, 32'd0);
        mem_abort = 1'b0;
        mem_cs    = 1'b0;
        repeat (5) @(negedge clk);

        // Reset at beat 1: outputs clear at once, array survives.
        do_read(10'd10, 2, acc);
        while (cyc < acc + LAT + 1) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_data",  rsp_data, 32'd0);
        chk("mid_rst_idx",   {30'd0, rsp_idx}, 32'd0);
        chk("mid_rst_last",  {31'd0, rsp_last}, 32'd0);
        chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
        mem_cs = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        do_read(10'd10, 4, acc);
        wait_idle("post_rst_idle");
        mem_cs = 1'b0;

        // Write followed two cycles later by a read of the same line.
        do_write(10'd9, 32'hDEAD_BEEF);
        do_read(10'd8, 4, acc);
        wait_idle("wr_rd_idle");
        mem_cs = 1'b0;

        // Top-of-array line.
        for (int i = 0; i < 4; i++) do_write(10'(1020 + i), 32'hC0DE_0000 + 32'(i));
        do_read(10'd1023, 4, acc);
        wait_idle("top_idle");
        mem_cs = 1'b0;

`ifdef IMEM_PARITY_EN
        do_write(10'd4, 32'h0000_0004);
        inj_req = 1'b1;
        do_write(10'd5, 32'h0000_0005);
        inj_req = 1'b0;
        do_write(10'd6, 32'h0000_0006);
        do_write(10'd7, 32'h0000_0007);
        do_read(10'd4, 4, acc);
        wait_idle("parity_idle");
        mem_cs = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("beats_drained",  32'(bq.size()), 32'd0);
        chk("writes_drained", 32'(wq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_line_server.md
# imem_line_server

Memory-side responder for the instruction-fetch miss path. It accepts line-fill reads and single-word test writes from the I-cache controller. Each read returns one cache line as a fixed-latency burst of words. The block owns the instruction storage array. Its deterministic latency is what the controller's startup calibration measures by writing and then reading back a test word.

## Interface
- ADDR_W, 10, word-address width; array depth is 2^ADDR_W words
- LINE_WORDS, 4, words per line; power of two, 1..16
- LATENCY, 13, cycles from request accept to first beat; legal range 1..14
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- mem_cs  in  1  access request, active high, level; the controller holds it high for the whole access
- mem_wen  in  1  active-low write select, sampled at accept (0 = write, 1 = read)
- mem_addr  in  ADDR_W  word address, sampled at accept
- mem_wdata  in  32  write data, sampled at accept
- mem_abort  in  1  fetch redirect (PC changed); cancels an in-flight read
- rsp_valid  out  1  beat valid
- rsp_data  out  32  beat data
- rsp_idx  out  log2(LINE_WORDS) (min 1)  word index of the beat within the line
- rsp_last  out  1  final beat of the line
- wr_done  out  1  one-cycle pulse when a write completes
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, WRITE, WAIT, BURST.
- Arm flag: set by reset and by any cycle with mem_cs=0. Cleared on accept. This prevents a held-high mem_cs from re-triggering an access.
- IDLE: accept when mem_cs=1 and armed.
  - If mem_wen=0, go to WRITE.
  - If mem_wen=1, latch the line base (mem_addr with its low log2(LINE_WORDS) bits cleared), clear the latency counter, and go to WAIT.
- WRITE: array[addr] <= wdata, wr_done=1 for this cycle, then IDLE.
- WAIT: the counter increments each cycle. When counter == LATENCY-1, go to BURST with beat index 0.
- BURST: one beat per cycle, index 0..LINE_WORDS-1, reading array[base+idx]. rsp_last is set on idx == LINE_WORDS-1. After the last beat, go to IDLE.
- Abort: mem_abort=1 in WAIT or BURST sends the block to IDLE at the next edge. No further beats are issued, and rsp_valid is 0 from that edge. mem_abort is ignored in IDLE and WRITE.
- Accept and abort in the same IDLE cycle: the accept wins.
- Address arithmetic is modulo 2^ADDR_W. The line base is always aligned, so a line never wraps mid-burst.
- Array contents are not reset and are undefined at power-up. Reset mid-access abandons the access and preserves the array.
- Reset values: state IDLE, armed=1, counter=0, and every output 0 (including rsp_data and rsp_idx).

## Timing
- Accept edge at cycle T. The first rsp_valid is registered-visible in cycle T+1+LATENCY. The last beat is at T+LATENCY+LINE_WORDS.
- Write: wr_done is visible in cycle T+1. A read of the same address accepted at T+2 or later returns the new data.
- rsp_* are registered. rsp_data, rsp_idx and rsp_last hold their last values when rsp_valid=0.
- Minimum spacing between accepts is one mem_cs=0 cycle after returning to IDLE.
- busy rises in cycle T+1 and falls in the cycle the block re-enters IDLE.

## Configuration
- IMEM_PARITY_EN: adds 1 even-parity bit per array word, computed on write and checked on each beat, plus an output port rsp_perr (1 bit, valid with rsp_valid, reset 0). Also adds input inj_perr (1 bit), which flips the stored parity bit on a write for test.
- Without the macro: no parity storage and neither port exists.

## Structure
- Shared package: the imem_state_t enum (IDLE, WRITE, WAIT, BURST) and the calibration constants IMEM_CAL_ADDR = 1 and IMEM_CAL_PATTERN = 32'hFFFF_FFFF, both shared with the I-cache controller.
- Sub-module imem_array: a single-port synchronous-read array with 1-cycle read latency, 32 bits wide plus an optional parity bit. The responder's latency counter accounts for that cycle.

## Test plan
- Calibration: write 32'hFFFF_FFFF to addr 1, then read addr 1 → wr_done at T+1; the read's first beat appears exactly 14 cycles after accept; beat 1 = FFFF_FFFF.
- Line burst: preload addr 8..11 with 0xA0..0xA3, read addr 10 → 4 beats 0xA0..0xA3, idx 0..3, rsp_last only on idx 3.
- Held mem_cs: keep mem_cs=1 for 40 cycles after a read → exactly one burst, busy low afterwards, no re-accept.
- Abort: assert mem_abort at accept+5 (in WAIT) and at beat 2 → rsp_valid=0 from the next edge, and a fresh read after mem_cs=0 works normally.
- Reset mid-burst: pull rstn low at beat 1 → all outputs 0 immediately; after release, re-reading returns the preloaded data unchanged.
- With IMEM_PARITY_EN: write with inj_perr=1, then read → rsp_perr=1 on that beat only.
